// File: rtl/dac_spi_monitor.sv
// dac_spi_monitor: deframes 16-bit DAC write words, flags bad frames and shadows ldac-latched channel codes
module dac_spi_monitor #(
   parameter int FRAME_BITS     = 16,
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        spi_sclk,
   input  logic        spi_sync_n,
   input  logic        spi_din,
   input  logic        spi_ldac_n,
   output logic        word_valid,
   output logic [15:0] word_data,
   output logic        word_chan,
   output logic [2:0]  word_ctrl,
   output logic [9:0]  word_code,
   output logic        frame_err,
   output logic [7:0]  err_cnt,
   output logic [9:0]  dac_a_code,
   output logic [9:0]  dac_b_code,
   output logic        latch_pulse
);
   localparam int CW = $clog2(FRAME_BITS + 2);
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_BITS);
   localparam logic [CW-1:0] CNT_MAX  = CW'(FRAME_BITS + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
   typedef enum logic [1:0] {IDLE, SHIFT, CHECK, ABORT} state_t;
   // bit order {ldac_n, din, sync_n, sclk}; zero reset so a pin held low at reset exit shows no fall
   logic [SYNC_STAGES-1:0][3:0] sync_q;
   logic [3:0] prev_q, cur;
   logic sclk_fall, sync_fall, sync_rise, ldac_fall;
   state_t state_q, state_d;
   logic [15:0] shreg_q, shreg_d, word_q, word_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [9:0] shadow_a_q, shadow_a_d, shadow_b_q, shadow_b_d, dac_a_q, dac_a_d, dac_b_q, dac_b_d;
   logic [7:0] err_cnt_q, err_cnt_d;
   logic valid_q, valid_d, err_q, err_d, latch_q, latch_d;
   assign cur       = sync_q[SYNC_STAGES-1];
   assign sclk_fall = prev_q[0] & ~cur[0];
   assign sync_fall = prev_q[1] & ~cur[1];
   assign sync_rise = ~prev_q[1] & cur[1];
   assign ldac_fall = prev_q[3] & ~cur[3];
   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      cnt_d      = cnt_q;
      tmo_d      = tmo_q;
      word_d     = word_q;
      shadow_a_d = shadow_a_q;
      shadow_b_d = shadow_b_q;
      valid_d    = 1'b0;
      err_d      = 1'b0;
      case (state_q)
         IDLE: if (sync_fall) begin
            state_d = SHIFT;
            cnt_d   = '0;
            tmo_d   = '0;
         end
         SHIFT: begin
            if (sclk_fall) begin
               shreg_d = {shreg_q[14:0], cur[2]};
               cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
            end
            tmo_d = tmo_q + 1'b1;
            if (tmo_q == TMO_LAST) begin
               err_d   = 1'b1;
               state_d = ABORT;
            end else if (sync_rise) state_d = CHECK;
         end
         CHECK: begin
            state_d = IDLE;
            if (cnt_q == CNT_FULL) begin
               valid_d    = 1'b1;
               word_d     = shreg_q;
               shadow_a_d = shreg_q[15] ? shadow_a_q : shreg_q[11:2];
               shadow_b_d = shreg_q[15] ? shreg_q[11:2] : shadow_b_q;
            end else err_d = 1'b1;
         end
         default: state_d = cur[1] ? IDLE : ABORT;
      endcase
      err_cnt_d = (err_d && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
      latch_d   = ldac_fall;
      dac_a_d   = ldac_fall ? shadow_a_d : dac_a_q;
      dac_b_d   = ldac_fall ? shadow_b_d : dac_b_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q     <= '0;
         prev_q     <= '0;
         state_q    <= IDLE;
         shreg_q    <= '0;
         cnt_q      <= '0;
         tmo_q      <= '0;
         word_q     <= '0;
         shadow_a_q <= '0;
         shadow_b_q <= '0;
         dac_a_q    <= '0;
         dac_b_q    <= '0;
         err_cnt_q  <= '0;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
         latch_q    <= 1'b0;
      end else begin
         sync_q     <= {sync_q[SYNC_STAGES-2:0], {spi_ldac_n, spi_din, spi_sync_n, spi_sclk}};
         prev_q     <= cur;
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         cnt_q      <= cnt_d;
         tmo_q      <= tmo_d;
         word_q     <= word_d;
         shadow_a_q <= shadow_a_d;
         shadow_b_q <= shadow_b_d;
         dac_a_q    <= dac_a_d;
         dac_b_q    <= dac_b_d;
         err_cnt_q  <= err_cnt_d;
         valid_q    <= valid_d;
         err_q      <= err_d;
         latch_q    <= latch_d;
      end
   end
   assign word_valid  = valid_q;
   assign word_data   = word_q;
   assign word_chan   = word_q[15];
   assign word_ctrl   = word_q[14:12];
   assign word_code   = word_q[11:2];
   assign frame_err   = err_q;
   assign err_cnt     = err_cnt_q;
   assign dac_a_code  = dac_a_q;
   assign dac_b_code  = dac_b_q;
   assign latch_pulse = latch_q;
endmodule
